// File: rtl/constraint_sample_sequencer.sv
// constraint_sample_sequencer
//
// Feeds pseudo-random candidate vectors to an external combinational
// constraint checker and streams out the candidates it accepts.
// A 32-bit Galois LFSR is stepped once per GEN cycle. Each stepped value
// fills one 32-bit word of the CAND_W-bit candidate, so one candidate
// takes CAND_W/32 cycles to build.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   start             : one-cycle pulse. Accepted only in IDLE or DONE.
//   seed              : LFSR seed loaded on an accepted start (0 -> 1)
//   num_samples       : samples to collect, captured on start
//   max_tries         : candidate budget, captured on start (0 = unlimited)
//   cand              : registered candidate driven to the checker
//   sat               : checker verdict for cand
//   out_valid/ready   : sample stream handshake
//   out_data          : sample payload, held while out_valid
//   busy/done/timeout : run status
//   accepted_cnt      : samples handed off this run (saturating)
//   tries_cnt         : candidates evaluated this run (saturating)
module constraint_sample_sequencer #(
  parameter int          CAND_W    = 512,
  parameter int          CHK_LAT   = 1,
  parameter logic [31:0] LFSR_TAPS = 32'h80200003
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       seed,
  input  logic [15:0]       num_samples,
  input  logic [23:0]       max_tries,
  output logic [CAND_W-1:0] cand,
  input  logic              sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CAND_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       accepted_cnt,
  output logic [23:0]       tries_cnt
);

  localparam int WORDS = CAND_W / 32;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  // The check counter runs 0..CHK_LAT-1. sat is sampled in the last of these cycles.
  localparam int CW    = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_CHECK,
    S_EMIT,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [31:0]     lfsr_reg;
  logic [31:0]     lfsr_step;
  logic [WW-1:0]   word_idx_reg;
  logic [CW-1:0]   chk_cnt_reg;
  logic [15:0]     num_samples_reg;
  logic [23:0]     max_tries_reg;
  logic            timeout_next;

  logic            start_ok;
  logic            gen_last;
  logic            sample_now;
  logic            handshake;
  logic            last_try;
  logic            budget_spent;
  logic            target_met;
  logic [23:0]     tries_inc;
  logic [15:0]     acc_inc;

  assign lfsr_step = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ LFSR_TAPS) : (lfsr_reg >> 1);

  assign start_ok   = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign gen_last   = (state_reg == S_GEN) && (word_idx_reg == WW'(WORDS - 1));
  assign sample_now = (state_reg == S_CHECK) && (chk_cnt_reg == CW'(CHK_LAT - 1));
  assign handshake  = (state_reg == S_EMIT) && out_ready;

  assign tries_inc = (tries_cnt == 24'hFFFFFF) ? tries_cnt : tries_cnt + 24'd1;
  assign acc_inc   = (accepted_cnt == 16'hFFFF) ? accepted_cnt : accepted_cnt + 16'd1;

  // Compared one bit wider so that the +1 can never wrap into a false match.
  assign last_try     = (max_tries_reg != 24'd0) &&
                        (({1'b0, tries_cnt} + 25'd1) == {1'b0, max_tries_reg});
  // In EMIT the try that produced the sample has already been counted.
  assign budget_spent = (max_tries_reg != 24'd0) && (tries_cnt == max_tries_reg);
  assign target_met   = (({1'b0, accepted_cnt} + 17'd1) == {1'b0, num_samples_reg});

  // Status outputs decode the state register only. This keeps sat off every
  // output path, and out_valid drops as soon as reset is asserted.
  assign out_valid = (state_reg == S_EMIT);
  assign busy      = (state_reg == S_GEN) || (state_reg == S_CHECK) || (state_reg == S_EMIT);
  assign done      = (state_reg == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      timeout   <= 1'b0;
    end else begin
      state_reg <= state_next;
      timeout   <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timeout_next = timeout;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_next   = (num_samples == 16'd0) ? S_DONE : S_GEN;
          timeout_next = 1'b0;
        end
      end
      S_GEN: begin
        if (gen_last) begin
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (sample_now) begin
          if (sat) begin
            state_next = S_EMIT;
          end else if (last_try) begin
            state_next   = S_DONE;
            timeout_next = 1'b1;
          end else begin
            state_next = S_GEN;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (target_met) begin
            state_next   = S_DONE;
            timeout_next = 1'b0;
          end else if (budget_spent) begin
            state_next   = S_DONE;
            timeout_next = 1'b1;
          end else begin
            state_next = S_GEN;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg        <= 32'd1;
      word_idx_reg    <= '0;
      chk_cnt_reg     <= '0;
      num_samples_reg <= 16'd0;
      max_tries_reg   <= 24'd0;
      cand            <= '0;
      out_data        <= '0;
      accepted_cnt    <= 16'd0;
      tries_cnt       <= 24'd0;
    end else begin
      if (start_ok) begin
        num_samples_reg <= num_samples;
        max_tries_reg   <= max_tries;
        lfsr_reg        <= (seed == 32'd0) ? 32'd1 : seed;
        accepted_cnt    <= 16'd0;
        tries_cnt       <= 24'd0;
      end

      // The word index restarts at zero every time GEN is left.
      word_idx_reg <= ((state_reg == S_GEN) && !gen_last) ? word_idx_reg + 1'b1 : '0;
      chk_cnt_reg  <= ((state_reg == S_CHECK) && !sample_now) ? chk_cnt_reg + 1'b1 : '0;

      if (state_reg == S_GEN) begin
        lfsr_reg <= lfsr_step;
        for (int i = 0; i < WORDS; i++) begin
          if (word_idx_reg == WW'(i)) begin
            cand[32*i +: 32] <= lfsr_step;
          end
        end
      end

      if (sample_now) begin
        tries_cnt <= tries_inc;
        if (sat) begin
          out_data <= cand;
        end
      end

      if (handshake) begin
        accepted_cnt <= acc_inc;
      end
    end
  end

endmodule

// File: tb/tb_constraint_sample_sequencer.sv
// Testbench for constraint_sample_sequencer (CAND_W=64, CHK_LAT=1).
// A transaction-level reference model predicts the sample list, the
// number of tries and the timeout flag for each run. The bench drives the
// checker input from a small predicate on cand.
module tb_constraint_sample_sequencer;

  localparam int          CAND_W  = 64;
  localparam int          CHK_LAT = 1;
  localparam int          WORDS   = CAND_W / 32;
  localparam logic [31:0] TAPS    = 32'h80200003;
  localparam logic [CAND_W-1:0] SEED1_CAND = 64'hC0300002_80200003;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       seed = 32'd0;
  logic [15:0]       num_samples = 16'd0;
  logic [23:0]       max_tries = 24'd0;
  logic [CAND_W-1:0] cand;
  logic              sat;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CAND_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [15:0]       accepted_cnt;
  logic [23:0]       tries_cnt;

  int tests = 0;
  int fails = 0;

  // Checker behaviour: 0 = always sat, 1 = never, 2 = two chosen vectors, 3 = low nibble below threshold
  int                sat_mode = 0;
  logic [CAND_W-1:0] hit_a = '0;
  logic [CAND_W-1:0] hit_b = '0;
  logic [3:0]        sat_thr = 4'd0;

  // Reference model results
  logic [CAND_W-1:0] exp_q[$];
  logic [CAND_W-1:0] got_q[$];
  int                exp_tries;
  int                exp_acc;
  bit                exp_to;
  int                first_valid;
  int                done_cyc;

  always #5 clk = ~clk;

  constraint_sample_sequencer #(
    .CAND_W   (CAND_W),
    .CHK_LAT  (CHK_LAT),
    .LFSR_TAPS(TAPS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .seed        (seed),
    .num_samples (num_samples),
    .max_tries   (max_tries),
    .cand        (cand),
    .sat         (sat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .accepted_cnt(accepted_cnt),
    .tries_cnt   (tries_cnt)
  );

  function automatic logic sat_fn(input logic [CAND_W-1:0] c, input int m,
                                  input logic [CAND_W-1:0] a, input logic [CAND_W-1:0] b,
                                  input logic [3:0] thr);
    case (m)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (c == a) || (c == b);
      default: return c[3:0] < thr;
    endcase
  endfunction

  assign sat = sat_fn(cand, sat_mode, hit_a, hit_b, sat_thr);

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // k-th candidate (1-based) produced from a seed
  function automatic logic [CAND_W-1:0] nth_cand(input logic [31:0] sd, input int k);
    logic [31:0]       s;
    logic [CAND_W-1:0] c;
    s = (sd == 32'd0) ? 32'd1 : sd;
    c = '0;
    for (int j = 0; j < k; j++) begin
      for (int w = 0; w < WORDS; w++) begin
        s = lstep(s);
        c[32*w +: 32] = s;
      end
    end
    return c;
  endfunction

  task automatic check_val(input string tag, input logic [CAND_W-1:0] got,
                           input logic [CAND_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Run-level model: list of emitted samples, tries used and timeout flag
  task automatic model_run(input logic [31:0] sd, input logic [15:0] ns, input logic [23:0] mt);
    logic [31:0]       s;
    logic [CAND_W-1:0] c;
    exp_q.delete();
    exp_tries = 0;
    exp_acc   = 0;
    exp_to    = 1'b0;
    if (ns == 16'd0) return;
    s = (sd == 32'd0) ? 32'd1 : sd;
    c = '0;
    while (exp_tries < 100000) begin
      for (int w = 0; w < WORDS; w++) begin
        s = lstep(s);
        c[32*w +: 32] = s;
      end
      exp_tries++;
      if (sat_fn(c, sat_mode, hit_a, hit_b, sat_thr)) begin
        exp_q.push_back(c);
        exp_acc++;
        if (exp_acc == int'(ns)) break;
      end
      if (mt != 24'd0 && exp_tries == int'(mt)) begin
        exp_to = 1'b1;
        break;
      end
    end
  endtask

  // rdy_mode: 0 = always ready, 1 = random, 2 = stall the first 10 valid cycles
  task automatic run_txn(input string tag, input logic [31:0] sd, input logic [15:0] ns,
                         input logic [23:0] mt, input int rdy_mode, input bit restart_mid);
    int                cyc;
    int                stall_n;
    bit                prev_stall;
    logic [CAND_W-1:0] prev_data;
    logic [CAND_W-1:0] prev_cand;
    model_run(sd, ns, mt);
    got_q.delete();
    first_valid = -1;
    done_cyc    = -1;
    stall_n     = 0;
    prev_stall  = 1'b0;
    prev_data   = '0;
    prev_cand   = '0;
    @(negedge clk);
    seed        = sd;
    num_samples = ns;
    max_tries   = mt;
    start       = 1'b1;
    out_ready   = (rdy_mode == 0);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      // A second start in GEN must be ignored
      start = restart_mid && (ns != 16'd0) && (cyc == 1);
      if (start) begin
        seed        = ~sd;
        num_samples = ns + 16'd1;
      end
      if (cyc == 1 && ns != 16'd0) check_val({tag, "_busy"}, CAND_W'(busy), CAND_W'(1));
      if (prev_stall) begin
        check_val({tag, "_stall_valid"}, CAND_W'(out_valid), CAND_W'(1));
        check_val({tag, "_stall_data"}, out_data, prev_data);
        check_val({tag, "_stall_cand"}, cand, prev_cand);
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc > 5000) begin
        check_val({tag, "_cycle_budget"}, CAND_W'(0), CAND_W'(1));
        break;
      end
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && stall_n < 10) begin
            out_ready = 1'b0;
            stall_n++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      if (out_valid && out_ready) got_q.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_cand  = cand;
    end
    start = 1'b0;
    check_val({tag, "_done"}, CAND_W'(done), CAND_W'(1));
    check_val({tag, "_valid_low"}, CAND_W'(out_valid), CAND_W'(0));
    check_val({tag, "_tries"}, CAND_W'(tries_cnt), CAND_W'(exp_tries));
    check_val({tag, "_accepted"}, CAND_W'(accepted_cnt), CAND_W'(exp_acc));
    check_val({tag, "_timeout"}, CAND_W'(timeout), CAND_W'(exp_to));
    check_val({tag, "_nsamples"}, CAND_W'(got_q.size()), CAND_W'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_val({tag, "_sample"}, got_q[i], exp_q[i]);
    end
    $display("[TB] %s seed=%h ns=%0d mt=%0d tries=%0d acc=%0d timeout=%0b samples=%0d first_valid=%0d done_cyc=%0d",
             tag, sd, ns, mt, tries_cnt, accepted_cnt, timeout, got_q.size(), first_valid, done_cyc);
  endtask

  initial begin
    int n;
    // Reset state
    #12;
    check_val("rst_valid", CAND_W'(out_valid), CAND_W'(0));
    check_val("rst_busy", CAND_W'(busy), CAND_W'(0));
    check_val("rst_done", CAND_W'(done), CAND_W'(0));
    check_val("rst_timeout", CAND_W'(timeout), CAND_W'(0));
    check_val("rst_cand", cand, '0);
    check_val("rst_data", out_data, '0);
    check_val("rst_acc", CAND_W'(accepted_cnt), CAND_W'(0));
    check_val("rst_tries", CAND_W'(tries_cnt), CAND_W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single sample, known candidate and latency
    sat_mode = 0;
    run_txn("basic", 32'd1, 16'd1, 24'd0, 0, 1'b0);
    check_val("basic_first_valid", CAND_W'(first_valid), CAND_W'(4));
    check_val("basic_done_cyc", CAND_W'(done_cyc), CAND_W'(5));
    check_val("basic_cand", cand, SEED1_CAND);
    if (got_q.size() > 0) check_val("basic_data", got_q[0], SEED1_CAND);

    // Budget exhaustion with no satisfying candidate
    sat_mode = 1;
    run_txn("budget", 32'd1, 16'd3, 24'd5, 0, 1'b0);
    check_val("budget_tries", CAND_W'(tries_cnt), CAND_W'(5));
    check_val("budget_timeout", CAND_W'(timeout), CAND_W'(1));
    check_val("budget_no_valid", CAND_W'(first_valid < 0), CAND_W'(1));

    // Every third candidate satisfies
    sat_mode = 2;
    hit_a = nth_cand(32'h1234, 3);
    hit_b = nth_cand(32'h1234, 6);
    run_txn("every3rd", 32'h1234, 16'd2, 24'd0, 0, 1'b0);
    check_val("every3rd_tries", CAND_W'(tries_cnt), CAND_W'(6));
    check_val("every3rd_acc", CAND_W'(accepted_cnt), CAND_W'(2));
    if (got_q.size() > 1) begin
      check_val("every3rd_s0", got_q[0], hit_a);
      check_val("every3rd_s1", got_q[1], hit_b);
    end

    // Last budgeted try satisfies but target not met: emits then times out
    run_txn("lasttry", 32'h1234, 16'd2, 24'd3, 0, 1'b0);
    check_val("lasttry_timeout", CAND_W'(timeout), CAND_W'(1));

    // Back-pressure: 10 stalled cycles in EMIT
    sat_mode = 0;
    run_txn("backpressure", 32'hDEADBEEF, 16'd2, 24'd0, 2, 1'b0);

    // Seed 0 behaves like seed 1
    run_txn("seed0", 32'd0, 16'd1, 24'd0, 0, 1'b0);
    check_val("seed0_first_valid", CAND_W'(first_valid), CAND_W'(4));
    if (got_q.size() > 0) check_val("seed0_data", got_q[0], SEED1_CAND);

    // start pulsed in GEN is ignored
    run_txn("restart_mid", 32'h55, 16'd2, 24'd0, 1, 1'b1);

    // Zero samples requested
    run_txn("zero_samples", 32'd7, 16'd0, 24'd0, 0, 1'b0);
    check_val("zero_done_cyc", CAND_W'(done_cyc), CAND_W'(1));

    // Reset during EMIT
    out_ready = 1'b0;
    @(negedge clk);
    seed = 32'd1; num_samples = 16'd1; max_tries = 24'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("midrst_reach_emit", CAND_W'(out_valid), CAND_W'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_valid", CAND_W'(out_valid), CAND_W'(0));
    check_val("midrst_busy", CAND_W'(busy), CAND_W'(0));
    check_val("midrst_cand", cand, '0);
    check_val("midrst_data", out_data, '0);
    check_val("midrst_tries", CAND_W'(tries_cnt), CAND_W'(0));
    $display("[TB] midrst valid=%0b busy=%0b cand=%h", out_valid, busy, cand);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn("after_reset", 32'd1, 16'd1, 24'd0, 0, 1'b0);
    if (got_q.size() > 0) check_val("after_reset_data", got_q[0], SEED1_CAND);

    // Randomized runs
    sat_mode = 3;
    for (int r = 0; r < 25; r++) begin
      sat_thr = 4'($urandom_range(4, 15));
      run_txn("rand", $urandom, 16'($urandom_range(0, 4)), 24'($urandom_range(0, 12)),
              1, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
